// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial bit source feeding a single-bit d_in
// of a downstream Mealy sequence detector.
//
// A WIDTH-bit word is accepted through a valid/ready handshake and shifted
// out one bit per clock on a registered d_out.
//
// Handshake: a word is accepted on a rising edge where load_valid and
// load_ready are both high. load_data is captured on that edge. load_valid
// seen while load_ready is low has no effect, so upstream must hold the word
// until it is accepted. load_ready is high in IDLE and on the last bit of a
// word, which lets back-to-back words stream with no gap.
//
// Optional feature: define SER_PARITY_EN to append one even-parity bit
// (XOR of all data bits) after the data bits of every word.
//
// The FSM state is visible through busy (high exactly in SHIFT).

module bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             d_out,
  output logic             d_out_valid,
  output logic             busy,
  output logic             word_done
);

`ifdef SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] LAST   = CW'(NBITS - 1);
  localparam logic [CW-1:0] PENULT = CW'(NBITS - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] frame;
  logic [WIDTH-1:0] data_ord;
  logic [CW-1:0]    count;
  logic             last;
  logic             accept;

  // Reorder the incoming word so the first bit to send sits at the top.
  always_comb begin
    data_ord = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) data_ord[i] = load_data[i];
      else           data_ord[i] = load_data[WIDTH-1-i];
    end
  end

  // Build the outgoing frame; bit NBITS-1 goes out first.
  always_comb begin
`ifdef SER_PARITY_EN
    frame = {data_ord, ^load_data};
`else
    frame = data_ord;
`endif
  end

  assign last   = (state == SHIFT) && (count == LAST);
  assign accept = load_valid && load_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic: leave SHIFT only on the last bit with no new word.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? SHIFT : IDLE;
      SHIFT:   if (last) state_next = accept ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: ready in IDLE or on the last bit, busy while shifting.
  always_comb begin
    load_ready = (state == IDLE) || last;
    busy       = (state == SHIFT);
  end

  // Datapath: shift register, bit counter and registered serial outputs.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      shreg       <= '0;
      count       <= '0;
      d_out       <= IDLE_LEVEL;
      d_out_valid <= 1'b0;
      word_done   <= 1'b0;
    end else if (accept) begin
      // First bit goes straight to d_out; the rest wait in the shifter.
      shreg       <= {frame[NBITS-2:0], 1'b0};
      count       <= '0;
      d_out       <= frame[NBITS-1];
      d_out_valid <= 1'b1;
      word_done   <= 1'b0;
    end else if ((state == SHIFT) && !last) begin
      shreg       <= {shreg[NBITS-2:0], 1'b0};
      count       <= count + 1'b1;
      d_out       <= shreg[NBITS-1];
      d_out_valid <= 1'b1;
      word_done   <= (count == PENULT);
    end else begin
      count       <= '0;
      d_out       <= IDLE_LEVEL;
      d_out_valid <= 1'b0;
      word_done   <= 1'b0;
    end
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial bit source that sits directly upstream of the Mealy sequence-detector FSM and drives its single-bit d_in input. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on a registered d_out. Back-to-back words produce a gap-free bit stream. A d_out_valid qualifier marks the cycles that carry real data.

Parameters:
WIDTH, 8, data bits per word; legal range is WIDTH >= 2.
MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.
IDLE_LEVEL, 1'b0, value driven on d_out while no bit is valid.

Ports:
clk  in  1  single clock; all logic updates on the rising edge.
n_reset  in  1  synchronous, active-low reset.
load_data  in  WIDTH  word to serialize; sampled only on an accept.
load_valid  in  1  upstream holds load_data valid.
load_ready  out  1  block can accept a word this cycle.
d_out  out  1  registered serial bit; feeds the downstream FSM d_in.
d_out_valid  out  1  d_out carries a data or parity bit this cycle.
busy  out  1  high while in the SHIFT state.
word_done  out  1  one-cycle pulse, coincident with the last bit of a word.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on n_reset, sampled only at the rising edge of clk.
- Reset values: state = IDLE, shift register = 0, bit counter = 0, d_out = IDLE_LEVEL, d_out_valid = 0, busy = 0, word_done = 0. load_ready = 1 (combinational, derived from state).
- Reset mid-word: the word is aborted and the remaining bits are discarded. The next accept starts a fresh word.
- Accept: occurs at an edge where load_valid && load_ready. load_data is captured at that edge.
- Latency: the first bit appears on d_out in the cycle immediately after the accept edge, i.e. one cycle of latency.
- States:
  - IDLE: load_ready = 1. On accept -> SHIFT with count = 0, first bit driven. Otherwise d_out = IDLE_LEVEL and d_out_valid = 0.
  - SHIFT: one bit is presented per cycle with d_out_valid = 1; count increments each edge.
  - SHIFT on the last bit (count == NBITS-1): word_done = 1 and load_ready = 1.
    - On accept in this cycle -> stay in SHIFT, reload the shift register, count = 0. The next cycle carries bit 0 of the new word with no bubble.
    - With no accept -> IDLE.
  - SHIFT on any other bit: load_ready = 0. load_valid is ignored and upstream must hold the word until it is accepted.
- NBITS: WIDTH, or WIDTH+1 when parity is enabled. The counter is clog2(NBITS) bits wide; its terminal compare is exact with no wrap-past.
- Bit order:
  - MSB_FIRST = 1: load_data[WIDTH-1] down to [0].
  - MSB_FIRST = 0: [0] up to [WIDTH-1].
- Outputs: d_out, d_out_valid and word_done are registered, so they are glitch-free for the detector.
- busy equals (state == SHIFT).
- Simultaneous events: reset has priority over accept. load_valid while load_ready = 0 has no effect.

Optional Feature:
Macro SER_PARITY_EN.
- Defined: one even-parity bit (XOR of all WIDTH data bits) is appended after the data bits, so NBITS = WIDTH+1. The parity bit is computed at accept time. word_done and load_ready assert on the parity bit.
- Undefined: no parity logic; NBITS = WIDTH.

Test Plan:
- Reset, then load 8'hA5 (MSB_FIRST=1) -> d_out = 1,0,1,0,0,1,0,1 on the 8 cycles after accept. d_out_valid is high for exactly 8 cycles and word_done pulses on the 8th. The state then returns to IDLE with d_out = 0.
- Back-to-back: 8'hFF accepted, then 8'h00 offered and held -> accept on the 8th bit cycle. Result is 16 contiguous valid bits (eight 1s, eight 0s) with no gap; word_done pulses twice, 8 cycles apart.
- Backpressure: load_valid raised at bit 3 of a word -> load_ready stays 0 for bits 3..6, rises on bit 7, and the second word is accepted there. No data loss or duplication.
- Reset mid-word: n_reset is low for 1 cycle at bit 4 of 8'hF0 -> the next cycle shows d_out = 0, d_out_valid = 0, busy = 0. A following 8'h81 serializes cleanly as 1,0,0,0,0,0,0,1.
- MSB_FIRST=0, load 8'h01 -> d_out = 1 then seven 0s.
- SER_PARITY_EN: 8'hA5 -> 9 bits, parity bit 0. 8'h07 -> parity bit 1. word_done pulses on the 9th bit.
- Detector chain: serializer output drives the FSM d_in, and the detector output is checked against the bit pattern produced by the above words.
